// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl_if
// Description : Handshake and control bundle between the AES round sequencer
//               (master) and the FIFO / datapath / key-store side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic              fifo_empty;
    logic              is_full;
    logic              read_fifo;
    logic              load_state;
    logic              state_en;
    logic              mix_en;
    logic [ADDR_W-1:0] round_key_addr;
    logic [3:0]        round_num;
    logic              data_valid;
    logic              data_done;
    logic              busy;
    logic [CNT_W-1:0]  block_count;

    modport master (
        input  fifo_empty, is_full,
        output read_fifo, load_state, state_en, mix_en, round_key_addr,
               round_num, data_valid, data_done, busy, block_count
    );

    modport slave (
        output fifo_empty, is_full,
        input  read_fifo, load_state, state_en, mix_en, round_key_addr,
               round_num, data_valid, data_done, busy, block_count
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl
// Description : Sequencing controller for the AES encryption datapath. Pops a
//               block, applies the initial AddRoundKey, steps the rounds with
//               one-cycle-ahead key prefetch and holds the ciphertext until
//               the output side accepts it. Every output is decoded from
//               registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int ADDR_W     = 4,
    parameter int CNT_W      = 16
) (
    input  wire logic          tb_clk,
    input  wire logic          tb_n_rst,
    aes_round_ctrl_if.master   bus
);

    // WAIT is the stalled part of DONE; ACK is the accepting DONE cycle.
    // Splitting DONE this way lets data_done come from a register instead of
    // a combinational path from is_full.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_ROUND = 3'd3,
        S_FINAL = 3'd4,
        S_WAIT  = 3'd5,
        S_ACK   = 3'd6
    } state_t;

    localparam logic [3:0]        c_LAST_MIX  = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0]        c_FINAL_RND = 4'(NUM_ROUNDS);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_ROUNDS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_round;
    logic [3:0]        w_round_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;

    logic              w_read_fifo;
    logic              w_load_state;
    logic              w_state_en;
    logic              w_mix_en;
    logic [ADDR_W-1:0] w_key_addr;
    logic [3:0]        w_round_num;
    logic              w_data_valid;
    logic              w_data_done;
    logic              w_busy;

    // State, round index and completed-block counter registers
    always_ff @(posedge tb_clk or negedge tb_n_rst) begin
        if (!tb_n_rst) begin
            r_state <= S_IDLE;
            r_round <= 4'd0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state, round-step and block-completion logic
    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (!bus.fifo_empty) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_round_nxt = 4'd1;
                w_state_nxt = (c_LAST_MIX == 4'd0) ? S_FINAL : S_ROUND;
            end
            S_ROUND: begin
                if (r_round >= c_LAST_MIX) begin
                    w_state_nxt = S_FINAL;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            S_FINAL: begin
                w_round_nxt = 4'd0;
                if (bus.is_full) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_ACK;
                    w_count_nxt = r_count + 1'b1;
                end
            end
            S_WAIT: begin
                if (!bus.is_full) begin
                    w_state_nxt = S_ACK;
                    w_count_nxt = r_count + 1'b1;
                end
            end
            S_ACK: begin
                w_state_nxt = bus.fifo_empty ? S_IDLE : S_READ;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_round_nxt = 4'd0;
            end
        endcase
    end

    // Output decode from registered state; key address runs one round ahead
    always_comb begin
        w_read_fifo  = 1'b0;
        w_load_state = 1'b0;
        w_state_en   = 1'b0;
        w_mix_en     = 1'b0;
        w_key_addr   = '0;
        w_round_num  = 4'd0;
        w_data_valid = 1'b0;
        w_data_done  = 1'b0;
        w_busy       = (r_state != S_IDLE);
        case (r_state)
            S_READ:  w_read_fifo  = 1'b1;
            S_LOAD:  w_load_state = 1'b1;
            S_ROUND: begin
                w_state_en  = 1'b1;
                w_mix_en    = 1'b1;
                w_round_num = r_round;
                w_key_addr  = ADDR_W'(r_round);
            end
            S_FINAL: begin
                w_state_en  = 1'b1;
                w_round_num = c_FINAL_RND;
                w_key_addr  = c_LAST_ADDR;
            end
            S_WAIT:  w_data_valid = 1'b1;
            S_ACK: begin
                w_data_valid = 1'b1;
                w_data_done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.read_fifo      = w_read_fifo;
    assign bus.load_state     = w_load_state;
    assign bus.state_en       = w_state_en;
    assign bus.mix_en         = w_mix_en;
    assign bus.round_key_addr = w_key_addr;
    assign bus.round_num      = w_round_num;
    assign bus.data_valid     = w_data_valid;
    assign bus.data_done      = w_data_done;
    assign bus.busy           = w_busy;
    assign bus.block_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_ctrl
// Description : Directed self-checking bench for aes_round_ctrl (CNT_W=4 so
//               the counter wrap is reachable in 16 blocks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

    localparam int c_NR = 10;

    // Phase codes used by the expectation function
    localparam int c_PH_IDLE  = 0;
    localparam int c_PH_READ  = 1;
    localparam int c_PH_LOAD  = 2;
    localparam int c_PH_ROUND = 3;
    localparam int c_PH_FINAL = 4;
    localparam int c_PH_WAIT  = 5;
    localparam int c_PH_ACK   = 6;

    logic tb_clk;
    logic tb_n_rst;
    int   n_checks;
    int   n_fail;

    aes_round_ctrl_if #(.ADDR_W(4), .CNT_W(4)) bus ();

    aes_round_ctrl #(
        .NUM_ROUNDS (c_NR),
        .ADDR_W     (4),
        .CNT_W      (4)
    ) dut (
        .tb_clk   (tb_clk),
        .tb_n_rst (tb_n_rst),
        .bus      (bus)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // {read,load,st_en,mix,valid,done,busy, addr[3:0], round[3:0], count[3:0]}
    function automatic logic [31:0] obs_vec();
        return {13'd0, bus.read_fifo, bus.load_state, bus.state_en, bus.mix_en,
                bus.data_valid, bus.data_done, bus.busy,
                bus.round_key_addr, bus.round_num, bus.block_count};
    endfunction

    // Hand-written expectation per control phase; r is the round number
    function automatic logic [31:0] exp_vec(input int ph, input int r, input int cnt);
        logic [6:0] f;
        logic [3:0] a;
        logic [3:0] rn;
        f  = 7'b0;
        a  = 4'd0;
        rn = 4'd0;
        case (ph)
            c_PH_READ:  f = 7'b1000001;
            c_PH_LOAD:  f = 7'b0100001;
            c_PH_ROUND: begin f = 7'b0011001; a = 4'(r); rn = 4'(r); end
            c_PH_FINAL: begin f = 7'b0010001; a = 4'(c_NR - 1); rn = 4'(c_NR); end
            c_PH_WAIT:  f = 7'b0000101;
            c_PH_ACK:   f = 7'b0000111;
            default:    f = 7'b0;
        endcase
        return {13'd0, f, a, rn, 4'(cnt)};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Key address is left unchecked while holding the result
    task automatic check_phase(input string tag, input int ph, input int r, input int cnt);
        logic [31:0] mask;
        mask = (ph == c_PH_WAIT || ph == c_PH_ACK) ? 32'hFFFF_F0FF : 32'hFFFF_FFFF;
        check_val(tag, obs_vec() & mask, exp_vec(ph, r, cnt) & mask);
    endtask

    // One block from READ to acceptance. Entered at the negedge before READ.
    task automatic run_block(input int stall, input bit last, input int cnt_before, input string tg);
        int cnt_after;
        cnt_after = (cnt_before + 1) % 16;
        for (int c = 1; c <= 12; c++) begin
            @(negedge tb_clk);
            if (c == 1)
                check_phase($sformatf("%s c%0d", tg, c), c_PH_READ, 0, cnt_before);
            else if (c == 2)
                check_phase($sformatf("%s c%0d", tg, c), c_PH_LOAD, 0, cnt_before);
            else if (c <= 11)
                check_phase($sformatf("%s c%0d", tg, c), c_PH_ROUND, c - 2, cnt_before);
            else
                check_phase($sformatf("%s c%0d", tg, c), c_PH_FINAL, 0, cnt_before);
            if (c == 1 && last) bus.fifo_empty = 1'b1;
            if (c == 11 && stall > 0) bus.is_full = 1'b1;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge tb_clk);
            check_phase($sformatf("%s wait%0d", tg, s), c_PH_WAIT, 0, cnt_before);
        end
        bus.is_full = 1'b0;
        @(negedge tb_clk);
        check_phase($sformatf("%s ack", tg), c_PH_ACK, 0, cnt_after);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        tb_n_rst       = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.is_full    = 1'b0;

        repeat (3) @(negedge tb_clk);
        check_val("reset", obs_vec(), 32'd0);
        tb_n_rst = 1'b1;

        // Idle with an empty FIFO
        for (int i = 0; i < 20; i++) begin
            @(negedge tb_clk);
            check_phase($sformatf("idle%0d", i), c_PH_IDLE, 0, 0);
        end

        // Single block, no stall
        bus.fifo_empty = 1'b0;
        run_block(0, 1'b1, 0, "single");
        @(negedge tb_clk);
        check_phase("single idle", c_PH_IDLE, 0, 1);

        // Output stall for 7 cycles
        bus.fifo_empty = 1'b0;
        run_block(7, 1'b1, 1, "stall");
        @(negedge tb_clk);
        check_phase("stall idle", c_PH_IDLE, 0, 2);

        // Three back-to-back blocks
        bus.fifo_empty = 1'b0;
        run_block(0, 1'b0, 2, "b2b0");
        run_block(0, 1'b0, 3, "b2b1");
        run_block(0, 1'b1, 4, "b2b2");
        @(negedge tb_clk);
        check_phase("b2b idle", c_PH_IDLE, 0, 5);

        // Reset during round 5
        bus.fifo_empty = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge tb_clk);
            if (c == 1) bus.fifo_empty = 1'b1;
        end
        check_phase("pre-rst r5", c_PH_ROUND, 5, 5);
        #2 tb_n_rst = 1'b0;
        #1 check_val("async rst", obs_vec(), 32'd0);
        @(negedge tb_clk);
        tb_n_rst = 1'b1;
        @(negedge tb_clk);
        check_phase("post-rst idle", c_PH_IDLE, 0, 0);
        bus.fifo_empty = 1'b0;
        run_block(0, 1'b1, 0, "post_rst");

        // 15 more blocks take the 4-bit counter from 1 through 15 to 0
        bus.fifo_empty = 1'b0;
        for (int i = 0; i < 15; i++) begin
            run_block(0, (i == 14), 1 + i, $sformatf("wrap%0d", i));
        end
        @(negedge tb_clk);
        check_val("wrap count", {28'd0, bus.block_count}, 32'd0);
        check_phase("wrap idle", c_PH_IDLE, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
